// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the packet-lock state encoding and the modulo-N pointer increment.
package stream_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   // Explicit wrap so non-power-of-two requester counts stay in range.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Zero latency; the grant is one-hot, or all-zero when nothing is requesting.
module rr_select #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_gnt
);

   logic [2*N-1:0] dbl;

   // Scanning the doubled vector downwards leaves the lowest hit at or above ptr.
   always_comb begin
      dbl     = {req, req};
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (dbl[i] && (i >= int'(ptr))) begin
            gnt_idx = IW'((i >= N) ? (i - N) : i);
            any_gnt = 1'b1;
         end
      end
      gnt[gnt_idx] = any_gnt;
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 stream arbiter with optional packet lock and a registered output slice.
// One cycle from accept to valid_o; full throughput, ready_o only while the output slot can load.
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int DW   = 8,
   parameter  int LOCK = 0,
   localparam int IW   = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic [N-1:0]  valid_i,
   output logic [N-1:0]  ready_o,
   input  logic [N*DW-1:0] data_i,
   input  logic [N-1:0]  last_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] data_o,
   output logic          last_o,
   output logic [IW-1:0] idx_o
);

   lock_state_e   state_q;
   logic [IW-1:0] lock_idx_q;
   logic [IW-1:0] ptr_q;
   logic [N-1:0]  lock_mask;
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          any_gnt;
   logic          load_en;
   logic          accept;

   // While locked only the owning requester may compete.
   assign lock_mask = {{(N-1){1'b0}}, 1'b1} << lock_idx_q;
   assign req       = (state_q == LOCKED) ? (valid_i & lock_mask) : valid_i;

   rr_select #(
      .N  (N),
      .IW (IW)
   ) u_rr_select (
      .req     (req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   assign load_en = ~valid_o | ready_i;
   assign ready_o = gnt & {N{load_en & ~clear_i & ~rst_i}};
   assign accept  = |ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         last_o  <= 1'b0;
         idx_o   <= '0;
         ptr_q   <= '0;
      end else if (clear_i) begin
         valid_o <= 1'b0;
         ptr_q   <= '0;
      end else if (accept) begin
         valid_o <= 1'b1;
         data_o  <= data_i[gnt_idx*DW +: DW];
         last_o  <= last_i[gnt_idx];
         idx_o   <= gnt_idx;
         ptr_q   <= IW'(wrap_inc(int'(gnt_idx), N));
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

   if (LOCK != 0) begin : g_lock
      lock_state_e   state_d;
      logic [IW-1:0] lock_idx_d;

      always_ff @(posedge clk_i) begin
         if (rst_i || clear_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
         end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
         end
      end

      always_comb begin
         state_d    = state_q;
         lock_idx_d = lock_idx_q;
         if (accept) begin
            case (state_q)
               IDLE: begin
                  // A single-beat packet never takes the lock.
                  if (!last_i[gnt_idx]) begin
                     state_d    = LOCKED;
                     lock_idx_d = gnt_idx;
                  end
               end
               LOCKED: begin
                  if ((gnt_idx == lock_idx_q) && last_i[gnt_idx]) begin
                     state_d = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end else begin : g_nolock
      assign state_q    = IDLE;
      assign lock_idx_q = '0;
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: a LOCK=0 and a LOCK=1 instance share one set of inputs.
// Per-cycle vector table plus hand-built lock/clear sequences; output beats go through a scoreboard.
module tb_stream_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            clear_i;
   logic [N-1:0]    valid_i;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    last_i;
   logic            ready_i;

   logic [N-1:0]  rdy0, rdy1;
   logic          vo0, vo1, lo0, lo1;
   logic [DW-1:0] do0, do1;
   logic [IW-1:0] io0, io1;

   stream_rr_arbiter #(.N(N), .DW(DW), .LOCK(0)) dut0 (
      .clk_i (clk_i), .rst_i (rst_i), .clear_i (clear_i),
      .valid_i (valid_i), .ready_o (rdy0), .data_i (data_i), .last_i (last_i),
      .valid_o (vo0), .ready_i (ready_i), .data_o (do0), .last_o (lo0), .idx_o (io0)
   );

   stream_rr_arbiter #(.N(N), .DW(DW), .LOCK(1)) dut1 (
      .clk_i (clk_i), .rst_i (rst_i), .clear_i (clear_i),
      .valid_i (valid_i), .ready_o (rdy1), .data_i (data_i), .last_i (last_i),
      .valid_o (vo1), .ready_i (ready_i), .data_o (do1), .last_o (lo1), .idx_o (io1)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [N-1:0]  vld;
      logic          rdy;
      logic [N-1:0]  exp_rdy;
      logic          exp_vo;
      logic [IW-1:0] exp_idx;
   } vec_t;

   typedef struct {
      logic [DW-1:0] dat;
      logic          last;
      logic [IW-1:0] idx;
   } beat_t;

   vec_t            tbl [18];
   beat_t           q0 [$];
   beat_t           q1 [$];
   beat_t           b0, b1;
   logic [N*DW-1:0] dat_all;
   logic            chk0, chk1, mon0, mon1;
   int              n_vec = 0;
   int              n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t mk(input logic [N-1:0] onehot, input logic [N-1:0] lst);
      beat_t b;
      b = '{dat: '0, last: 1'b0, idx: '0};
      for (int k = 0; k < N; k++) begin
         if (onehot[k]) begin
            b.dat  = dat_all[k*DW +: DW];
            b.last = lst[k];
            b.idx  = IW'(k);
         end
      end
      return b;
   endfunction

   // One cycle: apply inputs, check combinational ready, record expected beats, step past the edge.
   task automatic drive(input logic [N-1:0] vld, input logic rdy, input logic [N-1:0] lst,
                        input logic clr, input logic [N-1:0] er0, input logic [N-1:0] er1);
      valid_i = vld;
      ready_i = rdy;
      last_i  = lst;
      clear_i = clr;
      data_i  = dat_all;
      #1;
      if (chk0) chk("ready_o dut0", rdy0, er0);
      if (chk1) chk("ready_o dut1", rdy1, er1);
      if (mon0 && (er0 != '0)) q0.push_back(mk(er0, lst));
      if (mon1 && (er1 != '0)) q1.push_back(mk(er1, lst));
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard: a beat is consumed at the edge where valid_o and ready_i are both high.
   always @(negedge clk_i) begin
      if (!rst_i && mon0 && vo0 && ready_i) begin
         if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb0 unexpected beat: got idx %0d data %0h, required none", io0, do0);
         end else begin
            b0 = q0.pop_front();
            chk("sb0 data", do0, b0.dat);
            chk("sb0 idx", io0, b0.idx);
            chk("sb0 last", lo0, b0.last);
         end
      end
      if (!rst_i && mon1 && vo1 && ready_i) begin
         if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb1 unexpected beat: got idx %0d data %0h, required none", io1, do1);
         end else begin
            b1 = q1.pop_front();
            chk("sb1 data", do1, b1.dat);
            chk("sb1 idx", io1, b1.idx);
            chk("sb1 last", lo1, b1.last);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //                 vld     rdy   exp_rdy  vo    idx
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[7]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
      tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
      for (int i = 11; i < 16; i++) tbl[i] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd0};
      tbl[16] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

      dat_all = 32'h4433_22A5;
      chk0 = 1'b1; chk1 = 1'b1; mon0 = 1'b0; mon1 = 1'b0;
      rst_i = 1'b1; clear_i = 1'b0; ready_i = 1'b0;
      valid_i = 4'hF; last_i = 4'hF; data_i = dat_all;

      // Reset: no requester may be readied while reset is held.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("reset ready_o dut0", rdy0, 4'b0000);
         chk("reset ready_o dut1", rdy1, 4'b0000);
      end
      @(posedge clk_i); #1;
      valid_i = 4'h0;
      rst_i   = 1'b0;
      @(posedge clk_i); #1;
      chk("reset valid_o", vo0, 1'b0);
      chk("reset data_o", do0, 8'h00);
      chk("reset idx_o", io0, 2'd0);
      chk("reset last_o", lo0, 1'b0);
      chk("reset valid_o dut1", vo1, 1'b0);

      // Round-robin, wrap/skip and backpressure; last=1 keeps the locking instance unlocked.
      mon0 = 1'b1; mon1 = 1'b1;
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].vld, tbl[i].rdy, 4'hF, 1'b0, tbl[i].exp_rdy, tbl[i].exp_rdy);
         chk("tbl valid_o dut0", vo0, tbl[i].exp_vo);
         chk("tbl valid_o dut1", vo1, tbl[i].exp_vo);
         chk("tbl idx_o dut0", io0, tbl[i].exp_idx);
         chk("tbl idx_o dut1", io1, tbl[i].exp_idx);
         chk("tbl data_o dut0", do0, dat_all[tbl[i].exp_idx*DW +: DW]);
         chk("tbl data_o dut1", do1, dat_all[tbl[i].exp_idx*DW +: DW]);
      end
      chk("sb0 drained", q0.size(), 0);

      // Packet lock on the LOCK=1 instance; pointer is at 2 here.
      chk0 = 1'b0; mon0 = 1'b0;
      dat_all[7:0] = 8'h01;
      drive(4'b0011, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0001);
      chk("lock beat1 idx", io1, 2'd0);
      dat_all[7:0] = 8'h02;
      drive(4'b0011, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0001);
      chk("lock beat2 idx", io1, 2'd0);
      drive(4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      chk("lock gap valid_o", vo1, 1'b0);
      drive(4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      dat_all[7:0] = 8'h03;
      drive(4'b0011, 1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0001);
      chk("lock beat3 last", lo1, 1'b1);
      chk("lock beat3 data", do1, 8'h03);
      drive(4'b0010, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0010);
      chk("after unlock idx", io1, 2'd1);
      drive(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000);

      // Clear while stalled and locked to requester 1.
      drive(4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0010);
      chk("pre-clear valid_o", vo1, 1'b1);
      drive(4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      chk("stall idx_o", io1, 2'd1);
      chk("stall valid_o", vo1, 1'b1);
      q1.delete();
      drive(4'b1001, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000);
      chk("clear valid_o", vo1, 1'b0);
      drive(4'b1001, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0001);
      chk("post-clear idx", io1, 2'd0);
      drive(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      chk("post-clear drain", vo1, 1'b0);
      chk("sb1 drained", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
